error_stage: RTL and testbench

Hardware replacement for the bench-side error computation behind `stage`. Joins the `expected` target stream with the `st_data_out` stream, computes `st_error = expected - st_data_out` in `float_24_8` through a 2-deep pipeline, and presents the result on the `st_error` handshake that `stage` consumes. It sits directly downstream of `stage`'s forward output and upstream of its error input.

---
 rtl/error_stage_pkg.sv | 16 +
 rtl/float_normalize.sv | 61 ++++++
 rtl/error_stage.sv | 139 +++++++++++++
 tb/tb_error_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/error_stage_pkg.sv
// error_stage_pkg: shared float_24_8 layout and default tuning constants for error_stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package error_stage_pkg;

   // float_24_8: sign, 8-bit biased exponent, 23-bit mantissa with hidden leading one
   typedef struct packed {
      logic        sgn;
      logic [7:0]  exp;
      logic [22:0] man;
   } float_24_8_t;

   localparam int FLUSH_EXP_DEF  = 10;
   localparam int NORM_DEPTH_DEF = 12;

endpackage

// File: rtl/float_normalize.sv
// float_normalize: leading-one search, round-to-nearest-even and flush of a 49-bit aligned sum.
// Latency: combinational. Optional ERROR_SCALE_EN adds error_shift_i exponent scaling.
// Backpressure: none; the enclosing pipeline stage decides when the result is captured.
module float_normalize
   import error_stage_pkg::*;
#(
   parameter int FLUSH_EXP  = FLUSH_EXP_DEF,
   parameter int NORM_DEPTH = NORM_DEPTH_DEF
) (
   input  logic [48:0] sum_i,
   input  logic [7:0]  big_exp_i,
`ifdef ERROR_SCALE_EN
   input  logic [3:0]  error_shift_i,
`endif
   output logic [31:0] result_o
);

   logic [48:0] mag;
   logic [46:0] norm;
   logic        found;
   logic [5:0]  lead_k;
   logic        rnd;
   logic [22:0] man;
   int          exp_i;
   float_24_8_t res;

   // Magnitude, leading-one position (smallest k wins), rounding and flush
   always_comb begin
      mag    = sum_i[48] ? (~sum_i + 49'd1) : sum_i;
      found  = 1'b0;
      lead_k = '0;
      for (int k = NORM_DEPTH - 1; k >= 0; k--) begin
         if (mag[47-k]) begin
            found  = 1'b1;
            lead_k = 6'(k);
         end
      end
      // shifting left by k puts the leading one at bit 47, so every slice becomes fixed
      norm = 47'(mag << lead_k);
      rnd  = norm[23] & ((|norm[22:0]) | norm[24]);
      if (found) begin
         // a rounding carry out of the mantissa wraps to zero, exponent is left alone
         man   = norm[46:24] + {22'd0, rnd};
         exp_i = int'(big_exp_i) + 1 - int'(lead_k);
      end else begin
         man   = '0;
         exp_i = int'(big_exp_i) + 1 - NORM_DEPTH;
      end
      res.sgn = sum_i[48];
      res.exp = exp_i[7:0];
      res.man = man;
`ifdef ERROR_SCALE_EN
      exp_i   = exp_i - int'(error_shift_i);
      res.exp = exp_i[7:0];
      if (exp_i < FLUSH_EXP || exp_i < 0) res = '0;
`endif
      if (mag == 49'd0 || int'(big_exp_i) < FLUSH_EXP) res = '0;
      result_o = res;
   end

endmodule

// File: rtl/error_stage.sv
// error_stage: joins expected with st_data_out and emits st_error = expected - st_data_out (float_24_8).
// Latency 2 cycles join->st_error_vld, full rate; ERROR_SCALE_EN adds the error_shift port.
// Backpressure: st_error_rdy low stalls stage 2, then stage 1, then drops both input rdy outputs.
module error_stage
   import error_stage_pkg::*;
#(
   parameter int FLUSH_EXP  = FLUSH_EXP_DEF,
   parameter int NORM_DEPTH = NORM_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] expected,
   input  logic        expected_vld,
   input  logic        expected_fst,
   output logic        expected_rdy,
   input  logic [31:0] st_data_out,
   input  logic        st_data_out_vld,
   input  logic        st_data_out_fst,
   output logic        st_data_out_rdy,
   output logic [31:0] st_error,
   output logic        st_error_vld,
   output logic        st_error_fst,
   input  logic        st_error_rdy,
`ifdef ERROR_SCALE_EN
   input  logic [3:0]  error_shift,
`endif
   output logic        fst_mismatch
);

   float_24_8_t        exp_f, dat_f;
   logic               adv1, adv2, join_fire;
   logic [8:0]         del;
   logic [7:0]         shamt, big_exp;
   logic signed [25:0] man_e, man_d;
   logic signed [48:0] op_e, op_d, sum_s;
   logic [31:0]        norm_res;

   logic        vld1_q, vld1_d, fst1_q, fst1_d;
   logic [48:0] sum1_q, sum1_d;
   logic [7:0]  exp1_q, exp1_d;
   logic        vld2_q, vld2_d, fst2_q, fst2_d;
   logic [31:0] err2_q, err2_d;
   logic        mism_q, mism_d;

   assign exp_f = expected;
   assign dat_f = st_data_out;

   assign adv2      = ~vld2_q | st_error_rdy;
   assign adv1      = ~vld1_q | adv2;
   assign join_fire = expected_vld & st_data_out_vld & adv1;

   // each side is only accepted together with the other, and never while reset is low
   assign expected_rdy    = reset & st_data_out_vld & adv1;
   assign st_data_out_rdy = reset & expected_vld & adv1;

   // Stage 1 datapath: align the smaller-exponent operand and add expected + (-st_data_out)
   always_comb begin
      del     = {1'b0, exp_f.exp} - {1'b0, dat_f.exp};
      shamt   = del[8] ? 8'(-del) : del[7:0];
      big_exp = del[8] ? dat_f.exp : exp_f.exp;
      man_e   = {2'b00, 1'b1, exp_f.man};
      man_d   = {2'b00, 1'b1, dat_f.man};
      if (exp_f.sgn)  man_e = -man_e;
      if (!dat_f.sgn) man_d = -man_d;
      op_e = {man_e, 23'd0};
      op_d = {man_d, 23'd0};
      if (del[8]) op_e = op_e >>> shamt;
      else        op_d = op_d >>> shamt;
      sum_s = op_e + op_d;
   end

   float_normalize #(
      .FLUSH_EXP  (FLUSH_EXP),
      .NORM_DEPTH (NORM_DEPTH)
   ) u_norm (
      .sum_i         (sum1_q),
      .big_exp_i     (exp1_q),
`ifdef ERROR_SCALE_EN
      .error_shift_i (error_shift),
`endif
      .result_o      (norm_res)
   );

   // Next state: stalled stages hold, advancing stages load from upstream
   always_comb begin
      vld1_d = vld1_q;
      fst1_d = fst1_q;
      sum1_d = sum1_q;
      exp1_d = exp1_q;
      vld2_d = vld2_q;
      fst2_d = fst2_q;
      err2_d = err2_q;
      mism_d = mism_q | (join_fire & (expected_fst ^ st_data_out_fst));
      if (adv1) begin
         vld1_d = join_fire;
         if (join_fire) begin
            fst1_d = st_data_out_fst;
            sum1_d = sum_s;
            exp1_d = big_exp;
         end
      end
      if (adv2) begin
         vld2_d = vld1_q;
         if (vld1_q) begin
            fst2_d = fst1_q;
            err2_d = norm_res;
         end
      end
   end

   // Pipeline registers with synchronous active-low reset dropping all in-flight data
   always_ff @(posedge clk) begin
      if (!reset) begin
         vld1_q <= 1'b0;
         fst1_q <= 1'b0;
         sum1_q <= '0;
         exp1_q <= '0;
         vld2_q <= 1'b0;
         fst2_q <= 1'b0;
         err2_q <= '0;
         mism_q <= 1'b0;
      end else begin
         vld1_q <= vld1_d;
         fst1_q <= fst1_d;
         sum1_q <= sum1_d;
         exp1_q <= exp1_d;
         vld2_q <= vld2_d;
         fst2_q <= fst2_d;
         err2_q <= err2_d;
         mism_q <= mism_d;
      end
   end

   assign st_error     = err2_q;
   assign st_error_vld = vld2_q;
   assign st_error_fst = fst2_q;
   assign fst_mismatch = mism_q;

endmodule

// File: tb/tb_error_stage.sv
// tb_error_stage: directed and randomized checks of error_stage against a float reference model.
// Model: exact integer difference, round-to-nearest-even, clamp and flush rules; in-order scoreboard.
// Backpressure: random st_error_rdy and input valids; a reset drops the scoreboard contents.
module tb_error_stage;
   import error_stage_pkg::*;

   localparam int FE = FLUSH_EXP_DEF;
   localparam int ND = NORM_DEPTH_DEF;
`ifdef ERROR_SCALE_EN
   localparam int          ESH = 1;
   localparam logic [31:0] T1  = 32'h3E800000;
   localparam logic [31:0] T2  = 32'hBE800000;
   logic [3:0] error_shift;
`else
   localparam int          ESH = 0;
   localparam logic [31:0] T1  = 32'h3F000000;
   localparam logic [31:0] T2  = 32'hBF000000;
`endif

   logic        clk, reset;
   logic [31:0] expected, st_data_out, st_error;
   logic        expected_vld, expected_fst, expected_rdy;
   logic        st_data_out_vld, st_data_out_fst, st_data_out_rdy;
   logic        st_error_vld, st_error_fst, st_error_rdy, fst_mismatch;

   typedef struct {
      logic [31:0] res;
      logic        fst;
      int          cyc;
   } ent_t;

   ent_t q[$];
   int   cyc, tests, fails, joins;
   logic mm_m, obs_join;

   error_stage dut (
      .clk             (clk),
      .reset           (reset),
      .expected        (expected),
      .expected_vld    (expected_vld),
      .expected_fst    (expected_fst),
      .expected_rdy    (expected_rdy),
      .st_data_out     (st_data_out),
      .st_data_out_vld (st_data_out_vld),
      .st_data_out_fst (st_data_out_fst),
      .st_data_out_rdy (st_data_out_rdy),
      .st_error        (st_error),
      .st_error_vld    (st_error_vld),
      .st_error_fst    (st_error_fst),
      .st_error_rdy    (st_error_rdy),
`ifdef ERROR_SCALE_EN
      .error_shift     (error_shift),
`endif
      .fst_mismatch    (fst_mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: exact value of e - d as an integer times 2^(lo-150), then rounded to 24 bits
   function automatic logic [31:0] ref_sub(input logic [31:0] e, input logic [31:0] d, input int esh);
      longint a, b, diff, mag, keep, rem, half, one;
      int ee, ed, lo, hi, p, rexp, r;
      logic sgn;
      logic [22:0] man;
      one = 1;
      ee = int'(e[30:23]);
      ed = int'(d[30:23]);
      lo = (ee < ed) ? ee : ed;
      hi = (ee < ed) ? ed : ee;
      a = longint'({1'b1, e[22:0]}) << (ee - lo);
      b = longint'({1'b1, d[22:0]}) << (ed - lo);
      if (e[31]) a = -a;
      if (d[31]) b = -b;
      diff = a - b;
      if (hi < FE || diff == 0) return 32'h0;
      sgn = (diff < 0);
      mag = sgn ? -diff : diff;
      p = 0;
      for (int i = 0; i < 60; i++) if ((mag >> i) != 0) p = i;
      rexp = lo + p - 23;
      if (rexp <= hi + 1 - ND) begin
         rexp = hi + 1 - ND;
         man  = '0;
      end else if (p <= 23) begin
         man = 23'(mag << (23 - p));
      end else begin
         r    = p - 23;
         keep = mag >> r;
         rem  = mag & ((one << r) - 1);
         half = one << (r - 1);
         if (rem > half || (rem == half && keep[0])) keep = keep + 1;
         man = 23'(keep);
      end
      if (esh != 0) begin
         rexp = rexp - esh;
         if (rexp < FE || rexp < 0) return 32'h0;
      end
      return {sgn, rexp[7:0], man};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive, check outputs against the model, clock, update the model
   task automatic cycle(input logic [31:0] e, input logic [31:0] d, input logic ef, input logic df,
                        input logic ev, input logic dv, input logic r, input logic rst);
      logic mvld, acc, jn, pop;
      ent_t ent;
      reset = rst; expected = e; st_data_out = d;
      expected_fst = ef; st_data_out_fst = df;
      expected_vld = ev; st_data_out_vld = dv; st_error_rdy = r;
      #1;
      mvld = (q.size() > 0) && (cyc >= q[0].cyc + 1);
      acc  = rst && ((q.size() < 2) || r);
      chk("expected_rdy", expected_rdy, acc & dv);
      chk("st_data_out_rdy", st_data_out_rdy, acc & ev);
      chk("st_error_vld", st_error_vld, mvld);
      if (mvld) begin
         chk("st_error", st_error, q[0].res);
         chk("st_error_fst", st_error_fst, q[0].fst);
      end
      chk("fst_mismatch", fst_mismatch, mm_m);
      obs_join = ev & dv & expected_rdy & st_data_out_rdy;
      jn  = acc & ev & dv;
      pop = mvld & r;
      @(posedge clk);
      cyc++;
      if (!rst) begin
         q.delete();
         mm_m = 1'b0;
      end else begin
         if (pop) void'(q.pop_front());
         if (jn) begin
            ent.res = ref_sub(e, d, ESH);
            ent.fst = df;
            ent.cyc = cyc;
            q.push_back(ent);
            if (ef != df) mm_m = 1'b1;
         end
      end
      #1;
   endtask

   task automatic rand_pair(output logic [31:0] e, output logic [31:0] d);
      int ee, ed, sel;
      sel = int'($urandom_range(0, 9));
      ee  = (sel == 0) ? int'($urandom_range(4, 14)) : int'($urandom_range(20, 200));
      ed  = ee + int'($urandom_range(0, 6)) - 3;
      e   = {1'b0, 8'(ee), 23'($urandom)};
      d   = {1'b0, 8'(ed), (sel >= 1 && sel <= 3) ? (e[22:0] ^ 23'($urandom_range(0, 255))) : 23'($urandom)};
   endtask

   task automatic rand_cycles(input int n, input int pv, input int pr);
      logic [31:0] e, d;
      logic f;
      for (int i = 0; i < n; i++) begin
         rand_pair(e, d);
         f = 1'($urandom_range(0, 1));
         cycle(e, d, f, f, int'($urandom_range(0, 99)) < pv, int'($urandom_range(0, 99)) < pv,
               int'($urandom_range(0, 99)) < pr, 1'b1);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      logic [31:0] e, d, first_res;
      tests = 0; fails = 0; cyc = 0; mm_m = 1'b0; joins = 0;
`ifdef ERROR_SCALE_EN
      error_shift = 4'd1;
`endif
      // reset held low with both inputs valid: outputs clear, rdy held low
      reset = 1'b0; expected = 32'h3F800000; st_data_out = 32'h3F000000;
      expected_vld = 1'b1; st_data_out_vld = 1'b1;
      expected_fst = 1'b1; st_data_out_fst = 1'b0; st_error_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_vld", st_error_vld, 1'b0);
      chk("rst_dat", st_error, 32'h0);
      chk("rst_fst", st_error_fst, 1'b0);
      chk("rst_mism", fst_mismatch, 1'b0);
      chk("rst_erdy", expected_rdy, 1'b0);
      chk("rst_drdy", st_data_out_rdy, 1'b0);

      // positive difference, fst passed through, 2-cycle latency
      cycle(32'h3F800000, 32'h3F000000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("t1_lat_vld", st_error_vld, 1'b0);
      idle(1);
      chk("t1_vld", st_error_vld, 1'b1);
      chk("t1_dat", st_error, T1);
      chk("t1_fst", st_error_fst, 1'b1);
      idle(1);
      // negative difference
      cycle(32'h3F000000, 32'h3F800000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(1);
      chk("t2_dat", st_error, T2);
      idle(1);
      // equal inputs
      cycle(32'h40000000, 32'h40000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(1);
      chk("t3_dat", st_error, 32'h0);
      chk("t3_vld", st_error_vld, 1'b1);
      idle(1);
      // flush on small exponent
      cycle(32'h02800000, 32'h02000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(1);
      chk("t4_flush", st_error, 32'h0);
      idle(2);

      // backpressure: 5 cycles of st_error_rdy low, both inputs always valid
      for (int i = 0; i < 5; i++) begin
         rand_pair(e, d);
         if (i == 0) first_res = ref_sub(e, d, ESH);
         cycle(e, d, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
         joins += int'(obs_join);
         if (i >= 1) chk("bp_stable", st_error, first_res);
      end
      chk("bp_joins", joins, 2);
      // release, then random traffic at full rate and with gaps
      rand_cycles(30, 100, 100);
      rand_cycles(60, 70, 60);
      idle(3);

      // frame check: differing fst bits set the sticky flag
      cycle(32'h3F800000, 32'h3F000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("fm_set", fst_mismatch, 1'b1);
      rand_cycles(20, 80, 70);
      chk("fm_sticky", fst_mismatch, 1'b1);
      idle(3);

      // reset mid-stream with both stages valid
      rand_pair(e, d);
      cycle(e, d, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      rand_pair(e, d);
      cycle(e, d, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("mr_full", st_error_vld, 1'b1);
      cycle(e, d, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("mr_vld", st_error_vld, 1'b0);
      chk("mr_mism", fst_mismatch, 1'b0);
      chk("mr_dat", st_error, 32'h0);
      rand_cycles(40, 80, 70);
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
